spi_mosi_rx: RTL

Slave-side deserializer for the SPI MOSI line, at the far end of the link from the team's MOSI transmitter. It receives frames made of one 8-bit address byte followed by one or more DSIZE-bit data words, all sent LSB first while `spi_cs` is low. It checks the address against SLAVE_ADDR and presents each received data word on a valid/ready handshake to the downstream FIFO write side. It also reports overrun and framing errors.

---
 rtl/spi_mosi_rx.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/spi_mosi_rx.sv
// rtl/spi_mosi_rx.sv - SPI MOSI slave deserializer: address byte, LSB-first data words, valid/ready output.
// Optional address filter and SKIP state: define SPI_RX_ADDR_FILTER_EN.
module spi_mosi_rx #(
  parameter int          DSIZE      = 8,
  parameter logic [7:0]  SLAVE_ADDR = 8'h46
) (
  input  logic             spi_clk,
  input  logic             n_reset,
  input  logic             spi_cs,
  input  logic             spi_mosi,
  input  logic             rx_ready,
  input  logic             clr_ovr,
  output logic [DSIZE-1:0] rx_data,
  output logic             rx_valid,
  output logic [7:0]       rx_addr,
  output logic             addr_match,
  output logic             rx_overrun,
  output logic             frame_err
);

  localparam int SW = (DSIZE > 8) ? DSIZE : 8;
  localparam int CW = $clog2(SW);

`ifdef SPI_RX_ADDR_FILTER_EN
  typedef enum logic [1:0] {IDLE, ADDR, DATA, SKIP} state_t;
`else
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
`endif

  state_t            r_state;
  state_t            w_state_next;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_next;
  logic [SW-2:0]     r_shift;
  logic              r_cs_q;
  logic [DSIZE-1:0]  r_rx_data;
  logic              r_rx_valid;
  logic [7:0]        r_rx_addr;
  logic              r_overrun;
  logic              r_frame_err;

  logic              w_shift_en;
  logic              w_addr_done;
  logic              w_word_done;
  logic              w_frame_err;
  logic [SW-1:0]     w_shift;
  logic [7:0]        w_addr;
  logic [DSIZE-1:0]  w_word;

  // The newest bit enters at the top, so the last N sampled bits are always the top N.
  assign w_shift = {spi_mosi, r_shift};
  assign w_addr  = w_shift[SW-1 -: 8];
  assign w_word  = w_shift[SW-1 -: DSIZE];

  always_ff @(posedge spi_clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_shift_en   = 1'b0;
    w_addr_done  = 1'b0;
    w_word_done  = 1'b0;
    w_frame_err  = 1'b0;
    case (r_state)
      // r_cs_q gates the start so a frame only begins on a fresh falling edge of spi_cs.
      IDLE: begin
        if (!spi_cs && r_cs_q) begin
          w_shift_en   = 1'b1;
          w_cnt_next   = CW'(1);
          w_state_next = ADDR;
        end
      end
      default: begin
        if (spi_cs) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
          w_frame_err  = (r_cnt != '0);
        end else begin
          w_shift_en = 1'b1;
          w_cnt_next = r_cnt + CW'(1);
          case (r_state)
            ADDR: begin
              if (r_cnt == CW'(7)) begin
                w_addr_done = 1'b1;
                w_cnt_next  = '0;
`ifdef SPI_RX_ADDR_FILTER_EN
                w_state_next = (w_addr == SLAVE_ADDR) ? DATA : SKIP;
`else
                w_state_next = DATA;
`endif
              end
            end
            DATA: begin
              if (r_cnt == CW'(DSIZE-1)) begin
                w_word_done = 1'b1;
                w_cnt_next  = '0;
              end
            end
`ifdef SPI_RX_ADDR_FILTER_EN
            SKIP: begin
              if (r_cnt == CW'(DSIZE-1)) begin
                w_cnt_next = '0;
              end
            end
`endif
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge spi_clk or negedge n_reset) begin
    if (!n_reset) begin
      r_shift     <= '0;
      r_cs_q      <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_rx_addr   <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_cs_q      <= spi_cs;
      r_frame_err <= w_frame_err;
      if (w_shift_en) begin
        r_shift <= w_shift[SW-1:1];
      end
      if (w_addr_done) begin
        r_rx_addr <= w_addr;
      end
      // A completing word may replace a word being consumed on the same edge.
      if (w_word_done && (!r_rx_valid || rx_ready)) begin
        r_rx_data  <= w_word;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      if (w_word_done && r_rx_valid && !rx_ready) begin
        r_overrun <= 1'b1;
      end else if (clr_ovr) begin
        r_overrun <= 1'b0;
      end
    end
  end

`ifdef SPI_RX_ADDR_FILTER_EN
  logic r_addr_match;

  always_ff @(posedge spi_clk or negedge n_reset) begin
    if (!n_reset) begin
      r_addr_match <= 1'b0;
    end else if (w_addr_done) begin
      r_addr_match <= (w_addr == SLAVE_ADDR);
    end
  end

  assign addr_match = r_addr_match;
`else
  assign addr_match = 1'b1;
`endif

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign rx_addr    = r_rx_addr;
  assign rx_overrun = r_overrun;
  assign frame_err  = r_frame_err;

endmodule
